// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and ROM fetch stage with valid/ready output, redirect and halt
module instr_fetch #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [ADDR_W-1:0]  PC_STEP   = ADDR_W'(1),
  parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic [31:0]       fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d, load, accept;
  logic [31:0]       count_q, count_d;
  always_comb begin
    accept     = valid_q && instr_ready;
    load       = (state_q == RUN) && !redirect_valid && (!valid_q || instr_ready);
    state_d    = redirect_valid ? RUN :
                 (state_q == BOOT) ? RUN :
                 (load && rom_data == HALT_WORD) ? HALTED : state_q;
    pc_d       = redirect_valid ? redirect_pc : load ? pc_q + PC_STEP : pc_q;
    instr_d    = load ? rom_data : instr_q;
    instr_pc_d = load ? pc_q : instr_pc_q;
    valid_d    = redirect_valid ? 1'b0 : load ? 1'b1 : accept ? 1'b0 : valid_q;
    count_d    = count_q + 32'(accept);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end
  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a transfer scoreboard plus state checks
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n, redirect_valid, instr_ready, instr_valid, halted, halt_en;
  logic [31:0] rom_addr, rom_data, redirect_pc, instr, instr_pc, fetch_count;
  typedef struct {logic [31:0] i; logic [31:0] p;} exp_t;
  exp_t exp_q[$];
  int   total = 0, passed = 0;

  always #5 clk = ~clk;

  assign rom_data = (halt_en && rom_addr == 32'd5) ? 32'hFFFF_FFFF : rom_addr + 32'h100;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted), .fetch_count(fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    exp_q.push_back('{i, p});
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL xfer_unexpected: got instr 0x%08h pc 0x%08h expected none", instr, instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_instr", instr, e.i);
        chk("xfer_pc", instr_pc, e.p);
      end
    end
  end

  initial begin
    int bad;
    rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_en = 1'b0;
    step(2);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    push(32'h100, 32'h0); push(32'h101, 32'h1); push(32'h102, 32'h2);
    rst_n = 1'b1;
    step;
    chk("boot_valid", 32'(instr_valid), 32'h0);
    step;
    chk("first_instr", instr, 32'h100);
    step(2);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("stall_instr", instr, 32'h102);
      chk("stall_pc", instr_pc, 32'h2);
      chk("stall_addr", rom_addr, 32'h3);
    end
    chk("stall_count", fetch_count, 32'h2);
    instr_ready = 1'b1;
    step;
    chk("post_stall_instr", instr, 32'h103);
    chk("post_stall_count", fetch_count, 32'h3);
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step;
    redirect_valid = 1'b0;
    chk("redir_squash", 32'(instr_valid), 32'h0);
    chk("redir_addr", rom_addr, 32'h40);
    step;
    chk("redir_instr", instr, 32'h140);
    chk("redir_pc", instr_pc, 32'h40);
    push(32'h140, 32'h40); push(32'h104, 32'h4); push(32'hFFFF_FFFF, 32'h5);
    halt_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4; instr_ready = 1'b1;
    step;
    redirect_valid = 1'b0;
    chk("redir_xfer_count", fetch_count, 32'h4);
    step(2);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_instr", instr, 32'hFFFF_FFFF);
    chk("halt_pc", instr_pc, 32'h5);
    chk("halt_addr", rom_addr, 32'h6);
    step;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (instr_valid || rom_addr != 32'h6) bad++;
      step;
    end
    chk("halt_idle", 32'(bad), 32'h0);
    chk("halt_count", fetch_count, 32'h6);
    chk("halt_hold", 32'(halted), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0;
    step;
    redirect_valid = 1'b0;
    chk("unhalt_flag", 32'(halted), 32'h0);
    chk("unhalt_valid", 32'(instr_valid), 32'h0);
    step;
    chk("refetch_instr", instr, 32'h100);
    chk("refetch_pc", instr_pc, 32'h0);
    push(32'h100, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; instr_ready = 1'b1;
    step;
    redirect_valid = 1'b0;
    push(32'h0000_00FF, 32'hFFFF_FFFF);
    chk("wrap_addr", rom_addr, 32'hFFFF_FFFF);
    step(2);
    instr_ready = 1'b0;
    chk("wrap_instr_pc", instr_pc, 32'h0);
    chk("wrap_next_addr", rom_addr, 32'h1);
    rst_n = 1'b0;
    step;
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    chk("midrst_addr", rom_addr, 32'h0);
    chk("midrst_count", fetch_count, 32'h0);
    chk("midrst_halted", 32'(halted), 32'h0);
    rst_n = 1'b1;
    step;
    chk("midrst_boot", 32'(instr_valid), 32'h0);
    step;
    chk("midrst_refetch", instr, 32'h100);
    chk("midrst_refetch_valid", 32'(instr_valid), 32'h1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
